// File: rtl/ysyx_22050550_trapu.sv
// ysyx_22050550_trapu -- machine-mode trap sequencer.
//
// Accepts one retiring instruction per handshake. On an event (pending
// timer interrupt, ecall or mret), it does three things:
//   - emits a single CSR write-back beat to the register file,
//   - issues one redirect PC to fetch,
//   - holds flush high until fetch takes the redirect.
//
// Ports:
//   clock, reset                   clock, asynchronous active-high reset
//   commit_valid / commit_ready    retiring-instruction handshake
//   commit_pc, commit_ecall,
//   commit_mret                    retiring instruction and its trap flags
//   mepc..mip                      live CSR values from the register file
//   wbcsren, wbm*                  CSR write-back enables and data
//                                  (one-cycle beat)
//   flush                          squash younger pipeline contents
//   redirect_valid/_pc/_ready      redirect handshake towards fetch
module ysyx_22050550_trapu #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MTIP_BIT = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            commit_ecall,
  input  logic            commit_mret,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mcause,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  output logic [7:0]      wbcsren,
  output logic [XLEN-1:0] wbmepc,
  output logic [XLEN-1:0] wbmcause,
  output logic [XLEN-1:0] wbmtvec,
  output logic [XLEN-1:0] wbmstatus,
  output logic [XLEN-1:0] wbmie,
  output logic [XLEN-1:0] wbmip,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_IRQ   = 2'd1,
    EV_ECALL = 2'd2,
    EV_MRET  = 2'd3
  } event_t;

  localparam logic [7:0] EN_TRAP = 8'b0000_1011;
  localparam logic [7:0] EN_MRET = 8'b0000_1000;

  state_t          state_q, state_d;
  logic            commit_ready_q, commit_ready_d;
  logic [7:0]      wbcsren_q, wbcsren_d;
  logic [XLEN-1:0] wbmepc_q, wbmepc_d;
  logic [XLEN-1:0] wbmcause_q, wbmcause_d;
  logic [XLEN-1:0] wbmstatus_q, wbmstatus_d;
  logic            flush_q, flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            irq;
  event_t          ev;
  logic [XLEN-1:0] trap_status;
  logic [XLEN-1:0] mret_status;
  logic [XLEN-1:0] irq_cause;

  // mcause is never read and only the MTIP/MTIE bits of mie/mip matter.
  logic unused_inputs;
  assign unused_inputs = ^{mcause, mtvec[1:0], mie, mip};

  always_comb begin
    irq       = mstatus[3] & mie[MTIP_BIT] & mip[MTIP_BIT];
    irq_cause = '0;
    irq_cause[XLEN-1] = 1'b1;
    irq_cause[2:0]    = 3'd7;

    if (irq)               ev = EV_IRQ;
    else if (commit_ecall) ev = EV_ECALL;
    else if (commit_mret)  ev = EV_MRET;
    else                   ev = EV_NONE;

    trap_status        = mstatus;
    trap_status[7]     = mstatus[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;

    mret_status        = mstatus;
    mret_status[3]     = mstatus[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b11;
  end

  // The write beat is computed from the inputs present at accept and loaded
  // straight into the output registers. This is equivalent to latching the
  // CSRs and computing the beat during WRITE, but needs fewer registers.
  // Only the redirect target has to be carried across into REDIRECT.
  always_comb begin
    state_d          = state_q;
    commit_ready_d   = commit_ready_q;
    flush_d          = flush_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    target_d         = target_q;
    wbcsren_d        = '0;
    wbmepc_d         = '0;
    wbmcause_d       = '0;
    wbmstatus_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (commit_valid && commit_ready_q && ev != EV_NONE) begin
          state_d        = WRITE;
          commit_ready_d = 1'b0;
          flush_d        = 1'b1;
          if (ev == EV_MRET) begin
            wbcsren_d   = EN_MRET;
            wbmstatus_d = mret_status;
            target_d    = mepc;
          end else begin
            wbcsren_d   = EN_TRAP;
            wbmepc_d    = commit_pc;
            wbmcause_d  = (ev == EV_IRQ) ? irq_cause : XLEN'(11);
            wbmstatus_d = trap_status;
            target_d    = {mtvec[XLEN-1:2], 2'b00};
          end
        end
      end
      WRITE: begin
        state_d          = REDIRECT;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target_q;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d          = IDLE;
          redirect_valid_d = 1'b0;
          redirect_pc_d    = '0;
          flush_d          = 1'b0;
          commit_ready_d   = 1'b1;
        end
      end
      default: begin
        state_d          = IDLE;
        commit_ready_d   = 1'b1;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      commit_ready_q   <= 1'b1;
      wbcsren_q        <= '0;
      wbmepc_q         <= '0;
      wbmcause_q       <= '0;
      wbmstatus_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      target_q         <= '0;
    end else begin
      state_q          <= state_d;
      commit_ready_q   <= commit_ready_d;
      wbcsren_q        <= wbcsren_d;
      wbmepc_q         <= wbmepc_d;
      wbmcause_q       <= wbmcause_d;
      wbmstatus_q      <= wbmstatus_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      target_q         <= target_d;
    end
  end

  assign commit_ready   = commit_ready_q;
  assign wbcsren        = wbcsren_q;
  assign wbmepc         = wbmepc_q;
  assign wbmcause       = wbmcause_q;
  assign wbmtvec        = '0;
  assign wbmstatus      = wbmstatus_q;
  assign wbmie          = '0;
  assign wbmip          = '0;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ysyx_22050550_trapu.sv
// Testbench for ysyx_22050550_trapu. Stimulus pushes expected write beats
// and redirect targets into queues; a negedge monitor pops and compares them
// whenever the DUT presents a write beat or a redirect handshake.
module tb_ysyx_22050550_trapu;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic        commit_ready;
  logic [63:0] commit_pc;
  logic        commit_ecall;
  logic        commit_mret;
  logic [63:0] mepc, mcause, mtvec, mstatus, mie, mip;
  logic [7:0]  wbcsren;
  logic [63:0] wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [7:0]  en;
    logic [63:0] epc_w;
    logic [63:0] cause_w;
    logic [63:0] status_w;
    logic [63:0] target;
  } exp_t;

  exp_t        wq[$];
  logic [63:0] rq[$];

  ysyx_22050550_trapu #(.XLEN(64), .MTIP_BIT(7)) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_ecall(commit_ecall), .commit_mret(commit_mret),
    .mepc(mepc), .mcause(mcause), .mtvec(mtvec), .mstatus(mstatus),
    .mie(mie), .mip(mip),
    .wbcsren(wbcsren), .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec),
    .wbmstatus(wbmstatus), .wbmie(wbmie), .wbmip(wbmip),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 0 none, 1 timer interrupt, 2 ecall, 3 mret.
  function automatic int ref_kind(input logic ec, input logic mr,
                                  input logic [63:0] st, ie, ip);
    if (st[3] && ie[7] && ip[7]) return 1;
    if (ec) return 2;
    if (mr) return 3;
    return 0;
  endfunction

  function automatic exp_t ref_beat(input int kind, input logic [63:0] pc, epc,
                                    tvec, st);
    exp_t e;
    logic [63:0] mie_old, mpie_old;
    mie_old  = (st >> 3) & 64'd1;
    mpie_old = (st >> 7) & 64'd1;
    e.en = 8'h00; e.epc_w = 0; e.cause_w = 0; e.status_w = 0; e.target = 0;
    if (kind == 1 || kind == 2) begin
      e.en       = 8'h0B;
      e.epc_w    = pc;
      e.cause_w  = (kind == 1) ? 64'h8000_0000_0000_0007 : 64'd11;
      e.status_w = (st & ~64'h1888) | (mie_old << 7) | 64'h1800;
      e.target   = tvec & ~64'h3;
    end else if (kind == 3) begin
      e.en       = 8'h08;
      e.status_w = (st & ~64'h1888) | (mpie_old << 3) | 64'h1880;
      e.target   = epc;
    end
    return e;
  endfunction

  // Monitor: consumes write beats and redirect handshakes.
  always @(negedge clock) begin
    if (!reset) begin
      if (wbcsren !== 8'h00) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_beat", {56'd0, wbcsren}, 64'd0);
        end else begin
          exp_t e;
          e = wq.pop_front();
          chk("wbcsren",   {56'd0, wbcsren}, {56'd0, e.en});
          chk("wbmepc",    wbmepc,    e.epc_w);
          chk("wbmcause",  wbmcause,  e.cause_w);
          chk("wbmstatus", wbmstatus, e.status_w);
          chk("wbmtvec",   wbmtvec,   64'd0);
          chk("wbmie",     wbmie,     64'd0);
          chk("wbmip",     wbmip,     64'd0);
        end
      end
      if (redirect_valid === 1'b1 && redirect_ready === 1'b1) begin
        if (rq.size() == 0) begin
          chk("unexpected_redirect", redirect_pc, 64'd0);
        end else begin
          logic [63:0] t;
          t = rq.pop_front();
          chk("redirect_pc_handshake", redirect_pc, t);
        end
      end
    end
  end

  task automatic scramble();
    commit_pc    = {$urandom, $urandom};
    commit_ecall = 1'($urandom);
    commit_mret  = 1'($urandom);
    mepc         = {$urandom, $urandom};
    mcause       = {$urandom, $urandom};
    mtvec        = {$urandom, $urandom};
    mstatus      = {$urandom, $urandom};
    mie          = {$urandom, $urandom};
    mip          = {$urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_commit_ready"},   {63'd0, commit_ready}, 64'd1);
    chk({tag, "_wbcsren"},        {56'd0, wbcsren}, 64'd0);
    chk({tag, "_wbmepc"},         wbmepc, 64'd0);
    chk({tag, "_wbmcause"},       wbmcause, 64'd0);
    chk({tag, "_wbmstatus"},      wbmstatus, 64'd0);
    chk({tag, "_flush"},          {63'd0, flush}, 64'd0);
    chk({tag, "_redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, "_redirect_pc"},    redirect_pc, 64'd0);
  endtask

  // One full commit transaction. Inputs are changed right after the accept
  // edge to confirm the unit works from its own latched copies.
  task automatic issue(input logic [63:0] pc, input logic ec, input logic mr,
                       input logic [63:0] epc, tvec, st, ie, ip,
                       input int unsigned hold);
    int   kind;
    exp_t e;
    kind = ref_kind(ec, mr, st, ie, ip);
    e    = ref_beat(kind, pc, epc, tvec, st);
    chk("ready_before_accept", {63'd0, commit_ready}, 64'd1);
    commit_pc = pc; commit_ecall = ec; commit_mret = mr;
    mepc = epc; mtvec = tvec; mstatus = st; mie = ie; mip = ip;
    mcause = {$urandom, $urandom};
    commit_valid = 1'b1;
    if (kind != 0) begin
      wq.push_back(e);
      rq.push_back(e.target);
    end
    @(posedge clock); #1;
    commit_valid = 1'b0;
    scramble();
    if (kind == 0) begin
      chk("none_flush",        {63'd0, flush}, 64'd0);
      chk("none_commit_ready", {63'd0, commit_ready}, 64'd1);
      chk("none_wbcsren",      {56'd0, wbcsren}, 64'd0);
      @(posedge clock); #1;
      chk("none_flush_after",  {63'd0, flush}, 64'd0);
    end else begin
      chk("write_flush",          {63'd0, flush}, 64'd1);
      chk("write_commit_ready",   {63'd0, commit_ready}, 64'd0);
      chk("write_redirect_valid", {63'd0, redirect_valid}, 64'd0);
      @(posedge clock); #1;
      chk("redir_latency_valid",  {63'd0, redirect_valid}, 64'd1);
      chk("redir_wbcsren_clear",  {56'd0, wbcsren}, 64'd0);
      for (int i = 0; i < int'(hold); i++) begin
        chk("hold_redirect_valid", {63'd0, redirect_valid}, 64'd1);
        chk("hold_redirect_pc",    redirect_pc, e.target);
        chk("hold_flush",          {63'd0, flush}, 64'd1);
        chk("hold_commit_ready",   {63'd0, commit_ready}, 64'd0);
        @(posedge clock); #1;
      end
      redirect_ready = 1'b1;
      @(posedge clock); #1;
      redirect_ready = 1'b0;
      chk("done_redirect_valid", {63'd0, redirect_valid}, 64'd0);
      chk("done_flush",          {63'd0, flush}, 64'd0);
      chk("done_commit_ready",   {63'd0, commit_ready}, 64'd1);
      chk("done_redirect_pc",    redirect_pc, 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    commit_valid = 1'b0;
    redirect_ready = 1'b0;
    scramble();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("post_reset");

    // ecall into a non-aligned mtvec
    issue(64'h8000_0010, 1'b1, 1'b0, 64'h0, 64'h8000_0103, 64'hA_0000_0008,
          64'h0, 64'h0, 0);
    // mret back to mepc
    issue(64'h8000_0040, 1'b0, 1'b1, 64'h8000_0014, 64'h8000_0103,
          64'hA_0000_1880, 64'h0, 64'h0, 0);
    // timer interrupt beats ecall
    issue(64'h8000_0200, 1'b1, 1'b0, 64'h0, 64'h8000_0100, 64'h8,
          64'h80, 64'h80, 1);
    // interrupt pending but globally disabled, no trap flags
    issue(64'h8000_0204, 1'b0, 1'b0, 64'h0, 64'h8000_0100, 64'h0,
          64'h80, 64'h80, 0);
    // both ecall and mret set: treated as ecall
    issue(64'h8000_0300, 1'b1, 1'b1, 64'h1234, 64'h8000_0400, 64'h0,
          64'h0, 64'h0, 0);
    // slow fetch: redirect held 5 cycles
    issue(64'h8000_0010, 1'b1, 1'b0, 64'h0, 64'h8000_0103, 64'hA_0000_0008,
          64'h0, 64'h0, 5);

    // reset in the middle of REDIRECT with redirect_ready low
    commit_pc = 64'h8000_0500; commit_ecall = 1'b1; commit_mret = 1'b0;
    mstatus = 64'h0; mie = 64'h0; mip = 64'h0; mtvec = 64'h8000_0600;
    commit_valid = 1'b1;
    wq.push_back(ref_beat(2, 64'h8000_0500, 64'h0, 64'h8000_0600, 64'h0));
    @(posedge clock); #1;
    commit_valid = 1'b0;
    @(posedge clock); #1;
    chk("pre_reset_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("after_midreset");

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [63:0] st, ie, ip;
      st = {$urandom, $urandom};
      ie = {$urandom, $urandom};
      ip = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        ie[7] = 1'b1; ip[7] = 1'b1;
      end
      issue({$urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0), {$urandom, $urandom},
            {$urandom, $urandom}, st, ie, ip, $urandom_range(0, 3));
    end

    repeat (2) @(posedge clock); #1;
    chk("write_queue_drained",    64'(wq.size()), 64'd0);
    chk("redirect_queue_drained", 64'(rq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_trapu.md
# ysyx_22050550_trapu

Machine-mode trap sequencer for the ysyx_22050550 core. It takes the commit stage's retiring instruction and trap flags (ecall, mret) together with the live CSR values read from the register file. It detects pending timer interrupts, computes new mepc/mcause/mstatus values and drives the register file's CSR write-back port (wbcsren/wb* buses). It then issues a single redirect PC to the fetch unit and flushes the pipeline.

## Interface
Parameters:
- XLEN, 64, data/CSR width
- MTIP_BIT, 7, bit index of MTIE in mie and of MTIP in mip

Ports (reset is asynchronous, active-high; all outputs registered):
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- commit_valid  in  1  retiring instruction present
- commit_ready  out  1  unit can accept; 1 only in IDLE
- commit_pc  in  64  PC of retiring instruction
- commit_ecall  in  1  instruction is ecall
- commit_mret  in  1  instruction is mret
- mepc, mcause, mtvec, mstatus, mie, mip  in  64 each  current CSR values from the register file
- wbcsren  out  8  CSR write enables: [0] mepc, [1] mcause, [2] mtvec, [3] mstatus, [4] mie, [5] mip, [7:6] always 0
- wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip  out  64 each  CSR write data
- flush  out  1  squash younger pipeline contents
- redirect_valid  out  1  redirect PC is valid
- redirect_pc  out  64  new fetch PC
- redirect_ready  in  1  fetch accepts redirect

## Operation
- States: IDLE, WRITE, REDIRECT.
- Accept: commit_valid & commit_ready at a rising edge.
- Interrupt pending (irq) = mstatus[3] & mie[MTIP_BIT] & mip[MTIP_BIT]. It is sampled only at accept.
- Event priority at accept: irq > ecall > mret > none.
  - If both commit_ecall and commit_mret are set, the accept is treated as ecall.
- none: the instruction retires normally. The unit stays in IDLE and all outputs stay 0.
- irq/ecall/mret: the unit latches the event kind, commit_pc and all CSR inputs, then goes to WRITE. flush goes to 1.
- WRITE lasts one cycle and drives exactly one write beat.
  - Trap (irq or ecall): wbcsren = 8'b0000_1011.
    - wbmepc = latched pc.
    - wbmcause = 64'd11 for ecall, 64'h8000_0000_0000_0007 for irq.
    - wbmstatus = latched mstatus with MPIE[7] = old MIE[3], MIE[3] = 0, MPP[12:11] = 2'b11.
    - target = {mtvec[63:2], 2'b00}. Only direct mode is supported; mtvec[1:0] is ignored.
  - mret: wbcsren = 8'b0000_1000.
    - wbmstatus = latched mstatus with MIE[3] = old MPIE[7], MPIE[7] = 1, MPP[12:11] = 2'b11.
    - target = latched mepc.
  - Unused wb* buses drive 0. wbmtvec, wbmie and wbmip are always 0, and their enables are never set.
- REDIRECT: redirect_valid = 1 and redirect_pc = target. Both are held stable until redirect_ready, then the unit returns to IDLE.
- Reset mid-operation: the unit goes to IDLE immediately (asynchronous) and the pending redirect is discarded.

## Timing
- Reset values:
  - state = IDLE, commit_ready = 1.
  - wbcsren = 0, all wb* buses = 0.
  - flush = 0, redirect_valid = 0, redirect_pc = 0.
- Accept at edge k:
  - Cycle k..k+1 is WRITE: wbcsren is non-zero for exactly this cycle, and the register file samples it at edge k+1.
  - From edge k+1 the unit is in REDIRECT. redirect_valid rises, and the CSR inputs already show the updated values.
- Minimum latency from accept to redirect_valid: 1 cycle. Minimum occupancy: 2 cycles, longer if redirect_ready is low.
- flush is high from edge k through the edge at which the redirect handshake completes, then drops to 0.
- commit_ready is low from edge k until the cycle after the redirect handshake. Back-to-back trap instructions are therefore separated by at least 3 cycles.
- An irq that becomes pending while the unit is busy is not taken until the next accept. Because MIE is cleared by the trap, it is taken only after mret restores MIE.

## Test plan
- Reset asserted mid-REDIRECT with redirect_ready = 0 -> all outputs return to reset values in the same cycle; commit_ready = 1 after reset deassertion.
- ecall at pc 0x8000_0010, mtvec = 0x8000_0103, mstatus = 0xA_0000_0008 -> one-cycle wbcsren = 0x0B, wbmepc = 0x8000_0010, wbmcause = 11, wbmstatus = 0xA_0000_1880; next cycle redirect_pc = 0x8000_0100.
- mret with mepc = 0x8000_0014, mstatus = 0xA_0000_1880 -> wbcsren = 0x08, wbmstatus = 0xA_0000_1888, redirect_pc = 0x8000_0014.
- Timer interrupt: mstatus.MIE = 1, mie = 0x80, mip = 0x80, commit_ecall = 1 at pc 0x8000_0200 -> irq wins; wbmcause = 0x8000_0000_0000_0007, wbmepc = 0x8000_0200.
- Same interrupt setup with mstatus.MIE = 0 and no trap flags -> accepted as none; wbcsren stays 0, flush stays 0, commit_ready stays 1.
- ecall with redirect_ready held low for 5 cycles -> redirect_valid, redirect_pc and flush are stable for 5 cycles; commit_ready = 0 throughout; one handshake, then IDLE.
